univ_reg: RTL and testbench

Parametrised multi-mode register that generalises the team's 4-bit enable/reset data register to WIDTH bits. Each enabled clock it can hold, parallel-load, shift, count or (optionally) rotate. It also provides a registered carry/shift-out bit, a zero flag and an illegal-mode flag. It sits in the lab datapath wherever a loadable register, shifter or up/down counter is needed, replacing the fixed-width `dff` instances.

---
 rtl/univ_reg_pkg.sv | 17 +
 rtl/univ_reg_next.sv | 68 ++++++
 rtl/univ_reg.sv | 62 ++++++
 tb/tb_univ_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: mode width and mode encodings.
package univ_reg_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_INC  = 3'b100;
  localparam mode_t MODE_DEC  = 3'b101;
  localparam mode_t MODE_ROL  = 3'b110;
  localparam mode_t MODE_ROR  = 3'b111;

endpackage

// File: rtl/univ_reg_next.sv
// Combinational next-state logic for univ_reg: computes next q, carry/shift-out
// and illegal-mode flag for the selected operation.
// Optional feature: UNIV_REG_ROTATE_EN enables ROL/ROR; otherwise those modes are illegal.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_l,
  input  logic             ser_r,
  output logic [WIDTH-1:0] q_nxt,
  output logic             co_nxt,
  output logic             err_nxt
);

  // One extra bit so the carry/borrow falls out of the add/subtract directly.
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] sum;

  // Operation decode; unlisted (illegal) modes hold q and raise the error flag.
  always_comb begin
    q_nxt   = q;
    co_nxt  = 1'b0;
    err_nxt = 1'b0;
    sum     = '0;
    case (mode)
      MODE_HOLD: ;
      MODE_LOAD: q_nxt = d;
      MODE_SHL: begin
        q_nxt  = {q[WIDTH-2:0], ser_l};
        co_nxt = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt  = {ser_r, q[WIDTH-1:1]};
        co_nxt = q[0];
      end
      MODE_INC: begin
        sum    = {1'b0, q} + ONE;
        q_nxt  = sum[WIDTH-1:0];
        co_nxt = sum[WIDTH];
      end
      MODE_DEC: begin
        // Top bit of the widened difference is set only when q was zero (borrow).
        sum    = {1'b0, q} - ONE;
        q_nxt  = sum[WIDTH-1:0];
        co_nxt = sum[WIDTH];
      end
`ifdef UNIV_REG_ROTATE_EN
      MODE_ROL: begin
        q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
        co_nxt = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt  = {q[0], q[WIDTH-1:1]};
        co_nxt = q[0];
      end
      default: ;
`else
      default: err_nxt = 1'b1;
`endif
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// Parametrised multi-mode register: hold, load, shift, count and optional rotate,
// with registered carry-out, illegal-mode flag and combinational zero decode.
// Optional feature: UNIV_REG_ROTATE_EN (modes 110/111 rotate instead of flagging an error).
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_l,
  input  logic             ser_r,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero,
  output logic             mode_err
);

  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;
  logic             err_nxt;

  univ_reg_next #(.WIDTH(WIDTH)) u_next (
    .q       (q),
    .mode    (mode),
    .d       (d),
    .ser_l   (ser_l),
    .ser_r   (ser_r),
    .q_nxt   (q_nxt),
    .co_nxt  (co_nxt),
    .err_nxt (err_nxt)
  );

  // State update: clear beats enable, disabled cycles hold q and drop the pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q        <= INIT;
      co       <= 1'b0;
      mode_err <= 1'b0;
    end else if (clr) begin
      q        <= INIT;
      co       <= 1'b0;
      mode_err <= 1'b0;
    end else if (!en) begin
      co       <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      co       <= co_nxt;
      mode_err <= err_nxt;
    end
  end

  // Zero decode tracks q in the same cycle.
  always_comb zero = (q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg (WIDTH=8, INIT=0): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_univ_reg;

  logic       clk = 1'b0;
  logic       reset, en, clr, ser_l, ser_r;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       co, zero, mode_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_q   = 0;
  bit m_co  = 1'b0;
  bit m_err = 1'b0;

  univ_reg #(.WIDTH(8), .INIT(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .mode     (mode),
    .d        (d),
    .ser_l    (ser_l),
    .ser_r    (ser_r),
    .q        (q),
    .co       (co),
    .zero     (zero),
    .mode_err (mode_err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the model by one edge, settle past the edge.
  task automatic drive(input bit e, input bit c, input int md, input int dd, input bit sl, input bit sr);
    logic [2:0] mv;
    logic [7:0] dv;
    int old;
    mv = md[2:0];
    dv = dd[7:0];
    @(negedge clk);
    en = e; clr = c; mode = mv; d = dv; ser_l = sl; ser_r = sr;
    @(posedge clk);
    old   = m_q;
    m_co  = 1'b0;
    m_err = 1'b0;
    if (c) m_q = 0;
    else if (e) begin
      case (md)
        0: ;
        1: m_q = dd % 256;
        2: begin m_co = (old >= 128); m_q = (old * 2) % 256 + (sl ? 1 : 0); end
        3: begin m_co = (old % 2 == 1); m_q = old / 2 + (sr ? 128 : 0); end
        4: begin m_co = (old == 255); m_q = (old + 1) % 256; end
        5: begin m_co = (old == 0); m_q = (old + 255) % 256; end
`ifdef UNIV_REG_ROTATE_EN
        6: begin m_co = (old >= 128); m_q = (old * 2) % 256 + (old >= 128 ? 1 : 0); end
        7: begin m_co = (old % 2 == 1); m_q = old / 2 + (old % 2) * 128; end
`else
        6, 7: m_err = 1'b1;
`endif
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 3'd0; d = '0; ser_l = 1'b0; ser_r = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1 || mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: q=%h co=%b zero=%b err=%b, want q=00 co=0 zero=1 err=0", q, co, zero, mode_err);
    end
    @(negedge clk) reset = 1'b1;
    m_q = 0; m_co = 0; m_err = 0;
    drive(1, 0, 4, 0, 0, 0);
    drive(1, 0, 4, 0, 0, 0);
    drive(1, 0, 4, 0, 0, 0);
    // Assert reset in the middle of an INC cycle
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1 || mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: q=%h co=%b zero=%b err=%b, want q=00 co=0 zero=1 err=0", q, co, zero, mode_err);
    end
    @(negedge clk);
    en = 1'b0; reset = 1'b1;
    m_q = 0; m_co = 0; m_err = 0;
    drive(1, 0, 4, 0, 0, 0);
    n_tests++;
    if (q !== 8'h01 || co !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_inc: q=%h co=%b zero=%b, want q=01 co=0 zero=0", q, co, zero);
    end
  endtask

  task automatic test_shift();
    drive(1, 0, 1, 'hA5, 0, 0);
    drive(1, 0, 2, 0, 1, 0);
    n_tests++;
    if (q !== 8'h4B || co !== 1'b1) begin
      n_fail++;
      $display("FAIL shl: q=%h co=%b, want q=4B co=1", q, co);
    end
    drive(1, 0, 3, 0, 0, 0);
    n_tests++;
    if (q !== 8'h25 || co !== 1'b1 || mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL shr: q=%h co=%b err=%b, want q=25 co=1 err=0", q, co, mode_err);
    end
  endtask

  task automatic test_count_wrap();
    drive(1, 0, 1, 'hFF, 0, 0);
    drive(1, 0, 4, 0, 0, 0);
    n_tests++;
    if (q !== 8'h00 || co !== 1'b1 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_wrap: q=%h co=%b zero=%b, want q=00 co=1 zero=1", q, co, zero);
    end
    drive(1, 0, 5, 0, 0, 0);
    n_tests++;
    if (q !== 8'hFF || co !== 1'b1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_wrap: q=%h co=%b zero=%b, want q=FF co=1 zero=0", q, co, zero);
    end
    drive(1, 0, 5, 0, 0, 0);
    n_tests++;
    if (q !== 8'hFE || co !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_plain: q=%h co=%b, want q=FE co=0", q, co);
    end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 'h3C, 0, 0);
    n_tests++;
    if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_over_load: q=%h co=%b zero=%b, want q=00 co=0 zero=1", q, co, zero);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4, 0, 0, 0);
      n_tests++;
      if (q !== 8'h00 || co !== 1'b0) begin
        n_fail++;
        $display("FAIL en_low_hold[%0d]: q=%h co=%b, want q=00 co=0", i, q, co);
      end
    end
  endtask

  task automatic test_rotate();
    drive(1, 0, 1, 'h81, 0, 0);
    drive(1, 0, 6, 0, 0, 0);
`ifdef UNIV_REG_ROTATE_EN
    n_tests++;
    if (q !== 8'h03 || co !== 1'b1 || mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rol: q=%h co=%b err=%b, want q=03 co=1 err=0", q, co, mode_err);
    end
    drive(1, 0, 7, 0, 0, 0);
    n_tests++;
    if (q !== 8'h81 || co !== 1'b1 || mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ror: q=%h co=%b err=%b, want q=81 co=1 err=0", q, co, mode_err);
    end
`else
    n_tests++;
    if (q !== 8'h81 || co !== 1'b0 || mode_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_mode: q=%h co=%b err=%b, want q=81 co=0 err=1", q, co, mode_err);
    end
    drive(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (q !== 8'h81 || mode_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse_end: q=%h err=%b, want q=81 err=0", q, mode_err);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, int'($urandom_range(7, 0)),
            int'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      n_tests++;
      if (q !== m_q[7:0] || co !== m_co || zero !== (m_q == 0) || mode_err !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: q=%h co=%b zero=%b err=%b, want q=%h co=%b zero=%b err=%b",
                 i, q, co, zero, mode_err, m_q[7:0], m_co, (m_q == 0), m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_count_wrap();
    test_priority();
    test_rotate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
